// File: rtl/conv_dma_top.sv
// rtl/conv_dma_top.sv - 3x3 two-in/four-out convolution engine with an AXI-Stream weight loader.
// Raster window from two line buffers, then a three-stage window/accumulate/scale pipeline.
module conv_dma_top #(
  parameter int IMG_W        = 5,
  parameter int IMG_H        = 5,
  parameter int WEIGHT_COUNT = 77
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_weight_tdata,
  input  logic        s_axis_weight_tvalid,
  output logic        s_axis_weight_tready,
  input  logic        s_axis_weight_tlast,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  output logic        fifo_rd_en,
  output logic [31:0] o_data,
  output logic        o_valid
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [6:0] LAST_ADDR = 7'(WEIGHT_COUNT - 1);
  localparam logic [6:0] BIAS_BASE = 7'd72;

  logic [6:0]    addr_q, addr_d;
  logic          loaded_q, loaded_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic          o_valid_q, o_valid_d;
  logic [31:0]   o_data_q, o_data_d;

  logic signed [7:0]  kern_q [72];
  logic [31:0]        bias_q [4];
  logic [31:0]        coeff_q;
  logic [15:0]        lb0_q [IMG_W];
  logic [15:0]        lb1_q [IMG_W];
  logic [15:0]        win_q [3][3];
  logic signed [31:0] acc_q [4];
  logic signed [31:0] acc_d [4];

  logic beat, consume;
  logic unused_hi;

  assign s_axis_weight_tready = 1'b1;
  assign beat       = s_axis_weight_tvalid & s_axis_weight_tready;
  assign consume    = loaded_q & i_valid;
  assign fifo_rd_en = loaded_q;
  assign o_data     = o_data_q;
  assign o_valid    = o_valid_q;
  assign unused_hi  = ^i_data[31:16];

  always_comb begin
    addr_d   = addr_q;
    loaded_d = loaded_q;
    col_d    = col_q;
    row_d    = row_q;
    if (beat) begin
      addr_d = (addr_q == LAST_ADDR || s_axis_weight_tlast) ? 7'd0 : addr_q + 7'd1;
      if (addr_q == LAST_ADDR) loaded_d = 1'b1;
    end
    if (consume) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    v1_d      = consume && (row_q >= RW'(2)) && (col_q >= CW'(2));
    v2_d      = v1_q;
    o_valid_d = v2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      loaded_q  <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      addr_q    <= addr_d;
      loaded_q  <= loaded_d;
      col_q     <= col_d;
      row_q     <= row_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  // Register file contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (beat) begin
      if (addr_q < BIAS_BASE)       kern_q[addr_q]      <= s_axis_weight_tdata[7:0];
      else if (addr_q < LAST_ADDR)  bias_q[addr_q[1:0]] <= s_axis_weight_tdata;
      else if (addr_q == LAST_ADDR) coeff_q             <= s_axis_weight_tdata;
    end
  end

  // Window column ky=0 is row-2 (from lb1), ky=2 is the incoming pixel.
  always_ff @(posedge clk) begin
    if (consume) begin
      lb0_q[col_q] <= i_data[15:0];
      lb1_q[col_q] <= lb0_q[col_q];
      for (int ky = 0; ky < 3; ky++) begin
        win_q[ky][0] <= win_q[ky][1];
        win_q[ky][1] <= win_q[ky][2];
      end
      win_q[0][2] <= lb1_q[col_q];
      win_q[1][2] <= lb0_q[col_q];
      win_q[2][2] <= i_data[15:0];
    end
  end

  always_comb begin : accumulate
    logic signed [16:0] wx;
    logic signed [16:0] xs;
    wx = '0;
    xs = '0;
    for (int oc = 0; oc < 4; oc++) begin
      acc_d[oc] = $signed(bias_q[oc]);
      for (int ic = 0; ic < 2; ic++) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            wx = 17'(kern_q[oc*18 + ic*9 + ky*3 + kx]);
            xs = $signed({9'b0, win_q[ky][kx][ic*8 +: 8]});
            acc_d[oc] = acc_d[oc] + 32'(wx * xs);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (v1_q) begin
      for (int oc = 0; oc < 4; oc++) acc_q[oc] <= acc_d[oc];
    end
  end

  // Coefficient is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin : scale
    logic signed [63:0] p;
    logic signed [63:0] q;
    p        = '0;
    q        = '0;
    o_data_d = o_data_q;
    if (v2_q) begin
      for (int oc = 0; oc < 4; oc++) begin
        p = 64'(acc_q[oc]) * $signed({32'b0, coeff_q});
        q = p >>> 28;
        if (q < 0)              o_data_d[oc*8 +: 8] = 8'h00;
        else if (q > 64'sd255)  o_data_d[oc*8 +: 8] = 8'hFF;
        else                    o_data_d[oc*8 +: 8] = q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_conv_dma_top.sv
// tb/tb_conv_dma_top.sv - directed and table-driven bench for conv_dma_top.
module tb_conv_dma_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axis_weight_tdata;
  logic        s_axis_weight_tvalid;
  logic        s_axis_weight_tready;
  logic        s_axis_weight_tlast;
  logic [31:0] i_data;
  logic        i_valid;
  logic        fifo_rd_en;
  logic [31:0] o_data;
  logic        o_valid;

  conv_dma_top #(.IMG_W(5), .IMG_H(5), .WEIGHT_COUNT(77)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_weight_tdata(s_axis_weight_tdata),
    .s_axis_weight_tvalid(s_axis_weight_tvalid),
    .s_axis_weight_tready(s_axis_weight_tready),
    .s_axis_weight_tlast(s_axis_weight_tlast),
    .i_data(i_data), .i_valid(i_valid), .fifo_rd_en(fifo_rd_en),
    .o_data(o_data), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  w;
    logic [31:0] bias;
    logic [31:0] coeff;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [7:0]  kw_m [72];
  logic [31:0] bias_m [4];
  logic [31:0] coeff_m;
  logic [7:0]  img [2][5][5][2];
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;

  always @(negedge clk) if (rst_n === 1'b1 && o_valid === 1'b1) got_q.push_back(o_data);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    s_axis_weight_tdata  = d;
    s_axis_weight_tlast  = last;
    s_axis_weight_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_weight_tvalid = 1'b0;
    s_axis_weight_tlast  = 1'b0;
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (i < 72) return {24'hA55A3C, kw_m[i]};
    if (i < 76) return bias_m[i-72];
    return coeff_m;
  endfunction

  task automatic load_all(input bit chk_rd);
    for (int i = 0; i < 77; i++) begin
      send_beat(word_at(i), i == 76);
      if (chk_rd) check("rd_en_during_load", {31'b0, fifo_rd_en}, {31'b0, (i == 76)});
    end
  endtask

  task automatic set_uniform(input vec_t v);
    for (int i = 0; i < 72; i++) kw_m[i] = v.w;
    for (int o = 0; o < 4; o++) bias_m[o] = v.bias;
    coeff_m = v.coeff;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        img[0][r][c][0] = v.p0;
        img[0][r][c][1] = v.p1;
      end
  endtask

  task automatic randomize_load();
    for (int i = 0; i < 72; i++) kw_m[i] = 8'($urandom);
    for (int o = 0; o < 4; o++) bias_m[o] = 32'($urandom_range(0, 40000)) - 32'd20000;
    coeff_m = 32'($urandom_range(50000, 200000));
  endtask

  task automatic randomize_img(input int f);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        for (int ic = 0; ic < 2; ic++) img[f][r][c][ic] = 8'($urandom);
  endtask

  // Reference computed directly on the image, independent of line buffering.
  task automatic model_frame(input int f);
    for (int r = 2; r < 5; r++)
      for (int c = 2; c < 5; c++) begin
        logic [31:0] word;
        word = '0;
        for (int oc = 0; oc < 4; oc++) begin
          int acc;
          longint p, q;
          acc = int'(bias_m[oc]);
          for (int ic = 0; ic < 2; ic++)
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++)
                acc += int'($signed(kw_m[oc*18 + ic*9 + ky*3 + kx])) *
                       int'(img[f][r-2+ky][c-2+kx][ic]);
          p = longint'(acc) * longint'({32'b0, coeff_m});
          q = p >>> 28;
          word[oc*8 +: 8] = (q < 0) ? 8'h00 : (q > 255) ? 8'hFF : q[7:0];
        end
        exp_q.push_back(word);
      end
  endtask

  task automatic stream(input int start, input int stop, input int gap_pct);
    int k;
    int budget;
    k = start;
    budget = 0;
    while (k < stop && budget < 5000) begin
      budget++;
      if ($urandom_range(0, 99) < gap_pct) begin
        i_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        i_data  = {16'($urandom), img[k/25][(k%25)/5][k%5][1], img[k/25][(k%25)/5][k%5][0]};
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        k++;
      end
    end
    if (k < stop) check("stream_budget", 32'(k), 32'(stop));
  endtask

  task automatic drain_and_compare(input string name, input int n);
    repeat (6) @(posedge clk);
    #1;
    check({name, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
      check(name, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{w: 8'h00, bias: 32'h00640000, coeff: 32'h00001000, p0: 8'd1,   p1: 8'd1,   exp: 32'h64646464};
    vecs[1] = '{w: 8'h01, bias: 32'h0,        coeff: 32'h10000000, p0: 8'd1,   p1: 8'd1,   exp: 32'h12121212};
    vecs[2] = '{w: 8'hFF, bias: 32'h0,        coeff: 32'h10000000, p0: 8'd1,   p1: 8'd1,   exp: 32'h00000000};
    vecs[3] = '{w: 8'h7F, bias: 32'h0,        coeff: 32'h10000000, p0: 8'd255, p1: 8'd255, exp: 32'hFFFFFFFF};
    vecs[4] = '{w: 8'h02, bias: 32'hFFFFFFF6, coeff: 32'h10000000, p0: 8'd3,   p1: 8'd4,   exp: 32'h74747474};
    vecs[5] = '{w: 8'h01, bias: 32'h0,        coeff: 32'h08000000, p0: 8'd10,  p1: 8'd20,  exp: 32'h87878787};

    rst_n = 1'b0;
    s_axis_weight_tdata = '0; s_axis_weight_tvalid = 1'b0; s_axis_weight_tlast = 1'b0;
    i_data = '0; i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tready", {31'b0, s_axis_weight_tready}, 32'd1);
    check("reset_rd_en",  {31'b0, fifo_rd_en}, 32'd0);
    check("reset_valid",  {31'b0, o_valid}, 32'd0);
    check("reset_data",   o_data, 32'd0);
    rst_n = 1'b1;

    // Pixels offered before the load completes must be ignored.
    i_data  = 32'h00010001;
    i_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("rd_en_preload", {31'b0, fifo_rd_en}, 32'd0);
    end
    set_uniform(vecs[0]);
    load_all(1'b1);
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("no_output_preload", 32'(got_q.size()), 32'd0);

    for (int v = 0; v < 6; v++) begin
      set_uniform(vecs[v]);
      if (v != 0) load_all(1'b0);
      repeat (9) exp_q.push_back(vecs[v].exp);
      stream(0, 25, 0);
      drain_and_compare($sformatf("vec%0d", v), 9);
    end

    randomize_load();
    load_all(1'b0);
    randomize_img(0);
    randomize_img(1);
    model_frame(0);
    model_frame(1);
    stream(0, 50, 30);
    drain_and_compare("two_frames", 18);

    // Latency: window-completing pixel (row 2, col 2) accepted at edge N, o_valid at N+2.
    randomize_img(0);
    model_frame(0);
    stream(0, 12, 0);
    i_data  = {16'h0, img[0][2][2][1], img[0][2][2][0]};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("lat_n",   {31'b0, o_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_n1",  {31'b0, o_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_n2",  {31'b0, o_valid}, 32'd1);
    stream(13, 25, 0);
    drain_and_compare("latency_frame", 9);

    // Reset mid-frame and mid-load, then a tlast-terminated partial load.
    randomize_img(0);
    stream(0, 12, 0);
    randomize_load();
    for (int i = 0; i < 40; i++) send_beat(word_at(i), 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    check("midrst_valid", {31'b0, o_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send_beat(32'h0000_00C3 + 32'(i), i == 9);
    check("rd_en_after_tlast", {31'b0, fifo_rd_en}, 32'd0);
    randomize_load();
    load_all(1'b0);
    check("rd_en_after_reload", {31'b0, fifo_rd_en}, 32'd1);
    randomize_img(0);
    model_frame(0);
    stream(0, 25, 20);
    drain_and_compare("after_reset", 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_dma_top.md
# conv_dma_top

Single-layer 3x3 convolution engine with an AXI4-Stream weight loader. Weights, biases and a requantisation coefficient are streamed in over an AXI-Stream slave and written into an internal weight register file. Pixels are then pulled from an upstream FIFO, convolved (2 input channels, 4 output channels, valid padding) and emitted as packed 8-bit results. It sits between a DMA/FIFO front end and the next layer's input buffer.

## Interface
- IMG_W, 5: image width in pixels (≥3).
- IMG_H, 5: image height in pixels (≥3).
- WEIGHT_COUNT, 77: weight words per load (72 kernel + 4 bias + 1 coeff); fixed by the address map.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_weight_tdata  in  32  weight word.
- s_axis_weight_tvalid  in  1  weight word valid.
- s_axis_weight_tready  out  1  loader ready; constant 1 out of reset.
- s_axis_weight_tlast  in  1  optional end-of-load marker.
- i_data  in  32  pixel word: [7:0] ch0, [15:8] ch1, both unsigned 8-bit; [31:16] ignored.
- i_valid  in  1  i_data valid (FIFO not empty).
- fifo_rd_en  out  1  engine accepts a pixel this cycle.
- o_data  out  32  {oc3, oc2, oc1, oc0}, each unsigned 8-bit.
- o_valid  out  1  o_data valid, 1-cycle pulse per output pixel.

## Operation
- Loader:
  - A beat is accepted on tvalid&&tready.
  - An internal address counter (0..76) writes the beat, then increments.
  - The counter returns to 0 after the beat at address 76 or after any beat with tlast.
- Address map:
  - 0..71: kernel words. Index = oc*18 + ic*9 + ky*3 + kx. The weight is tdata[7:0], signed.
  - 72..75: bias for oc0..oc3, signed 32-bit.
  - 76: coeff, unsigned 32-bit. Writing it sets `loaded`.
- `loaded` is cleared only by reset. Reloading weights mid-frame is permitted and takes effect on the next computed output.
- fifo_rd_en = loaded. A pixel is consumed when fifo_rd_en && i_valid.
- Window generation:
  - Two line buffers of IMG_W entries × 16 bits plus a 3x3×2-channel shift window.
  - Raster counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per consumed pixel.
  - At the end of the frame both counters wrap to 0 and the next frame starts.
- An output is produced for each consumed pixel with row≥2 and col≥2. This gives (IMG_W-2)×(IMG_H-2) outputs per frame, in raster order.
- Arithmetic per oc:
  - acc = bias[oc] + Σ_{ic,ky,kx} w·x. Products are signed 8 × unsigned 8; the accumulator is signed 32-bit and wraps.
  - p = acc × coeff, signed 64-bit.
  - q = p >>> 28 (arithmetic shift).
  - Output = clamp(q, 0, 255), i.e. ReLU plus saturation.

## Timing
- Reset values: s_axis_weight_tready=1, fifo_rd_en=0, o_data=0, o_valid=0, address counter=0, loaded=0, row=col=0. Weight and line-buffer contents are don't-care.
- Weight write latency: a beat accepted at edge N is visible to the datapath from edge N+1.
- fifo_rd_en rises the cycle after the coeff beat (address 76) is accepted.
- Datapath pipeline, counted from the edge at which the window-completing pixel is consumed (edge N):
  - Stage 1, edge N: window register.
  - Stage 2, edge N+1: accumulate.
  - Stage 3, edge N+2: scale/clamp. o_valid asserts at edge N+2 (latency 3 cycles counting the accept edge).
- No backpressure from downstream; o_valid is never stalled.
- Gaps in i_valid freeze the counters and window; the pipeline still drains.
- Asserting rst_n low mid-frame or mid-load immediately clears all counters, `loaded` and o_valid. Weights must then be reloaded.
- A weight beat coinciding with pixel consumption is allowed: the write completes first and the window uses the new value from the next cycle.

## Test plan
- Load 72 zero kernels, 4 biases of 0x00640000, coeff 0x00001000. Then stream 25 pixels of value 1 (5x5) -> 9 outputs, each o_data=0x64646464; fifo_rd_en=0 until the cycle after the coeff beat.
- Before load completes, drive i_valid=1 -> fifo_rd_en=0, no pixels consumed, o_valid never asserts.
- All kernel weights 1, bias 0, coeff 0x10000000, all pixels ch0=ch1=1 -> acc=18, each output byte 18 (0x12121212).
- Kernel weights -1, bias 0, pixels 1 -> q negative -> o_data=0x00000000 (ReLU). Weights 127, pixels 255, coeff 0x10000000 -> bytes saturate to 0xFF.
- Stream 2 back-to-back frames with random i_valid gaps -> 18 outputs, matching a reference model; counters wrap cleanly between frames.
- Assert rst_n low after 40 weight beats, then perform a full 77-beat load -> results match a clean load; tlast on beat 10 restarts addressing at 0.
